// File: rtl/vrf_masked_sb_if.sv
// Bus bundle for the vrf_masked_sb vector register file.
// Defining VRF_VSTART_EN adds the vstart / vstart_q pair.
interface vrf_masked_sb_if #(
    parameter int VLEN  = 64,
    parameter int NREG  = 32,
    parameter int AVL_W = 8,
    parameter int AW    = $clog2(NREG),
    parameter int VLW   = $clog2(VLEN/8) + 1
);
    logic [AW-1:0]    raA;
    logic [AW-1:0]    raB;
    logic [VLEN-1:0]  rdA;
    logic [VLEN-1:0]  rdB;
    logic             busyA;
    logic             busyB;
    logic [AW-1:0]    wa;
    logic [VLEN-1:0]  wd;
    logic             wen;
    logic             vm;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             cfg_valid;
    logic [6:0]       vtype_in;
    logic [AVL_W-1:0] AVL_in;
    logic [VLW-1:0]   vl;
    logic [6:0]       vtype;
    logic [AVL_W-1:0] AVL_reg;
`ifdef VRF_VSTART_EN
    logic [VLW-1:0]   vstart;
    logic [VLW-1:0]   vstart_q;
`endif

    modport master (
        output raA, raB, wa, wd, wen, vm, sb_set, sb_addr, cfg_valid, vtype_in, AVL_in,
`ifdef VRF_VSTART_EN
        output vstart,
        input  vstart_q,
`endif
        input  rdA, rdB, busyA, busyB, vl, vtype, AVL_reg
    );

    modport slave (
        input  raA, raB, wa, wd, wen, vm, sb_set, sb_addr, cfg_valid, vtype_in, AVL_in,
`ifdef VRF_VSTART_EN
        input  vstart,
        output vstart_q,
`endif
        output rdA, rdB, busyA, busyB, vl, vtype, AVL_reg
    );
endinterface

// File: rtl/vrf_masked_sb.sv
// RVV vector register file: element-masked writes, vl/vtype/AVL CSRs and a busy scoreboard.
// Optional macro VRF_VSTART_EN adds vstart-based suppression of leading elements.
module vrf_masked_sb #(
    parameter int VLEN  = 64,
    parameter int NREG  = 32,
    parameter int AVL_W = 8,
    parameter int AW    = $clog2(NREG),
    parameter int VLW   = $clog2(VLEN/8) + 1
) (
    input  logic           clk,
    input  logic           rst,
    vrf_masked_sb_if.slave bus
);
    localparam int NB = VLEN / 8;
    localparam int LW = $clog2(VLEN);

    logic [VLEN-1:0]  data [NREG];
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;
    logic [VLW-1:0]   vl_q;
    logic [VLW-1:0]   cfg_vl;
    logic [6:0]       vtype_q;
    logic [AVL_W-1:0] avl_q;
    logic             cfg_legal;
    logic [NB-1:0]    be;
    logic [VLEN-1:0]  bmask;
    logic [VLEN-1:0]  v0;
    logic [VLEN-1:0]  wr_merged;
    logic             vtype_in_unused;

    assign v0              = data[0];
    assign vtype_in_unused = bus.vtype_in[6];

`ifdef VRF_VSTART_EN
    logic [VLW-1:0] vstart_q;

    // A write retires the interrupted instruction, so it outranks a same-cycle vsetvl load.
    always_ff @(posedge clk) begin
        if (!rst)               vstart_q <= '0;
        else if (bus.wen)       vstart_q <= '0;
        else if (bus.cfg_valid) vstart_q <= bus.vstart;
    end

    assign bus.vstart_q = vstart_q;
`endif

    // vsetvl decode: only LMUL=1 and SEW up to VLEN are legal.
    always_comb begin
        int unsigned vlmax;
        cfg_legal = (bus.vtype_in[5:3] <= 3'd3)
                 && ((8 << bus.vtype_in[5:3]) <= VLEN)
                 && (bus.vtype_in[2:0] == 3'd0);
        vlmax  = NB >> bus.vtype_in[5:3];
        cfg_vl = (32'(bus.AVL_in) > vlmax) ? VLW'(vlmax) : VLW'(bus.AVL_in);
    end

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        logic [LW-1:0] e;
        logic          start_ok;
        be       = '0;
        bmask    = '0;
        e        = '0;
        start_ok = 1'b0;
        for (int b = 0; b < NB; b++) begin
            e = LW'(b) >> vtype_q[5:3];
`ifdef VRF_VSTART_EN
            start_ok = (e >= LW'(vstart_q));
`else
            start_ok = 1'b1;
`endif
            be[b] = bus.wen & ~vtype_q[6] & (e < LW'(vl_q)) & (bus.vm | v0[e]) & start_ok;
            bmask[8*b +: 8] = {8{be[b]}};
        end
    end

    assign wr_merged = (data[bus.wa] & ~bmask) | (bus.wd & bmask);

    // Bypass reuses the commit byte mask, so a read sees exactly what will land.
    assign bus.rdA = (bus.wen && (bus.wa == bus.raA))
                   ? ((data[bus.raA] & ~bmask) | (bus.wd & bmask)) : data[bus.raA];
    assign bus.rdB = (bus.wen && (bus.wa == bus.raB))
                   ? ((data[bus.raB] & ~bmask) | (bus.wd & bmask)) : data[bus.raB];

    // Clear first so a same-cycle set on the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (bus.wen)    busy_nxt[bus.wa]      = 1'b0;
        if (bus.sb_set) busy_nxt[bus.sb_addr] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the register file must read back zero after reset, so the storage is flops, not RAM.
            for (int r = 0; r < NREG; r++) data[r] <= '0;
            busy    <= '0;
            vl_q    <= '0;
            vtype_q <= '0;
            avl_q   <= '0;
        end else begin
            if (bus.wen) data[bus.wa] <= wr_merged;
            busy <= busy_nxt;
            if (bus.cfg_valid) begin
                avl_q <= bus.AVL_in;
                if (cfg_legal) begin
                    vl_q    <= cfg_vl;
                    vtype_q <= {1'b0, bus.vtype_in[5:0]};
                end else begin
                    vl_q    <= '0;
                    vtype_q <= 7'b100_0000;
                end
            end
        end
    end

    assign bus.vl      = vl_q;
    assign bus.vtype   = vtype_q;
    assign bus.AVL_reg = avl_q;
    assign bus.busyA   = busy[bus.raA];
    assign bus.busyB   = busy[bus.raB];
endmodule

// File: tb/tb_vrf_masked_sb.sv
// Self-checking bench for vrf_masked_sb: vector table with scoreboard queue plus
// hand-written bypass, scoreboard, reset and vstart sequences.
module tb_vrf_masked_sb;
    localparam int VLEN  = 64;
    localparam int NREG  = 32;
    localparam int AVL_W = 8;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [3:0]  vl;
        logic [6:0]  vtype;
        logic [7:0]  avl;
        logic [63:0] rd;
        logic        busy;
    } exp_t;

    typedef struct {
        logic        cfg;
        logic [6:0]  vt;
        logic [7:0]  avl;
        logic        wen;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        vm;
        logic        sb;
        logic [4:0]  sba;
        logic [4:0]  ra;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sbq[$];

    always #5 clk = ~clk;

    vrf_masked_sb_if #(.VLEN(VLEN), .NREG(NREG), .AVL_W(AVL_W)) bus ();

    vrf_masked_sb #(.VLEN(VLEN), .NREG(NREG), .AVL_W(AVL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cfg, input logic [6:0] vt, input logic [7:0] avl,
                         input logic wen, input logic [4:0] wa, input logic [63:0] wd,
                         input logic vm, input logic sb, input logic [4:0] sba);
        bus.cfg_valid = cfg;
        bus.vtype_in  = vt;
        bus.AVL_in    = avl;
        bus.wen       = wen;
        bus.wa        = wa;
        bus.wd        = wd;
        bus.vm        = vm;
        bus.sb_set    = sb;
        bus.sb_addr   = sba;
    endtask

    task automatic idle();
        drive(1'b0, 7'h00, 8'd0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 5'd0);
`ifdef VRF_VSTART_EN
        bus.vstart = '0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic void add(input logic cfg, input logic [6:0] vt, input logic [7:0] avl,
                                input logic wen, input logic [4:0] wa, input logic [63:0] wd,
                                input logic vm, input logic sb, input logic [4:0] sba,
                                input logic [4:0] ra, input logic [3:0] evl, input logic [6:0] evt,
                                input logic [7:0] eavl, input logic [63:0] erd, input logic ebusy);
        vec_t v;
        v.cfg = cfg; v.vt = vt; v.avl = avl; v.wen = wen; v.wa = wa; v.wd = wd;
        v.vm = vm; v.sb = sb; v.sba = sba; v.ra = ra;
        v.e.vl = evl; v.e.vtype = evt; v.e.avl = eavl; v.e.rd = erd; v.e.busy = ebusy;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t v;
        exp_t e;

        // cfg  vt     avl     wen wa  wd                     vm sb sba ra  vl vtype  avl     rd                      busy
        add(1, 7'h00, 8'd5,   0, 0,  64'h0,                 1, 0, 0,  3,  5, 7'h00, 8'd5,   64'h0,                  0);
        add(0, 7'h00, 8'd0,   1, 3,  ONES,                  1, 1, 3,  3,  5, 7'h00, 8'd5,   64'h0000_00FF_FFFF_FFFF, 1);
        add(1, 7'h10, 8'd200, 0, 0,  64'h0,                 1, 0, 0,  3,  2, 7'h10, 8'd200, 64'h0000_00FF_FFFF_FFFF, 1);
        add(0, 7'h00, 8'd0,   1, 5,  64'h1122334455667788,  1, 0, 0,  5,  2, 7'h10, 8'd200, 64'h1122334455667788,  0);
        add(1, 7'h19, 8'd9,   0, 0,  64'h0,                 1, 0, 0,  5,  0, 7'h40, 8'd9,   64'h1122334455667788,  0);
        add(0, 7'h00, 8'd0,   1, 6,  ONES,                  1, 0, 0,  6,  0, 7'h40, 8'd9,   64'h0,                  0);
        add(1, 7'h00, 8'd8,   0, 0,  64'h0,                 1, 0, 0,  6,  8, 7'h00, 8'd8,   64'h0,                  0);
        add(0, 7'h00, 8'd0,   1, 0,  64'h5,                 1, 0, 0,  0,  8, 7'h00, 8'd8,   64'h5,                  0);
        add(0, 7'h00, 8'd0,   1, 4,  64'h1122334455667788,  0, 0, 0,  4,  8, 7'h00, 8'd8,   64'h0000_0000_0066_0088, 0);
        add(0, 7'h00, 8'd0,   1, 0,  ONES,                  0, 0, 0,  0,  8, 7'h00, 8'd8,   64'h0000_0000_00FF_00FF, 0);
        add(1, 7'h08, 8'd3,   0, 0,  64'h0,                 1, 0, 0,  0,  3, 7'h08, 8'd3,   64'h0000_0000_00FF_00FF, 0);
        add(0, 7'h00, 8'd0,   1, 9,  ONES,                  1, 0, 0,  9,  3, 7'h08, 8'd3,   64'h0000_FFFF_FFFF_FFFF, 0);
        add(1, 7'h18, 8'd0,   0, 0,  64'h0,                 1, 0, 0,  9,  0, 7'h18, 8'd0,   64'h0000_FFFF_FFFF_FFFF, 0);
        add(0, 7'h00, 8'd0,   1, 9,  64'h0,                 1, 0, 0,  9,  0, 7'h18, 8'd0,   64'h0000_FFFF_FFFF_FFFF, 0);
        add(1, 7'h20, 8'd1,   0, 0,  64'h0,                 1, 0, 0,  9,  0, 7'h40, 8'd1,   64'h0000_FFFF_FFFF_FFFF, 0);
        add(1, 7'h18, 8'd1,   0, 0,  64'h0,                 1, 0, 0,  9,  1, 7'h18, 8'd1,   64'h0000_FFFF_FFFF_FFFF, 0);
        add(0, 7'h00, 8'd0,   1, 9,  64'h0102030405060708,  1, 0, 0,  9,  1, 7'h18, 8'd1,   64'h0102030405060708,  0);
        add(1, 7'h00, 8'd2,   1, 10, ONES,                  1, 0, 0,  10, 2, 7'h00, 8'd2,   ONES,                   0);
        add(0, 7'h00, 8'd0,   1, 10, 64'h0,                 1, 0, 0,  10, 2, 7'h00, 8'd2,   64'hFFFF_FFFF_FFFF_0000, 0);
        add(1, 7'h00, 8'd8,   0, 0,  64'h0,                 1, 0, 0,  10, 8, 7'h00, 8'd8,   64'hFFFF_FFFF_FFFF_0000, 0);
        add(1, 7'h40, 8'hFF,  0, 0,  64'h0,                 1, 0, 0,  10, 8, 7'h00, 8'hFF,  64'hFFFF_FFFF_FFFF_0000, 0);

        // Power-on reset
        rst = 1'b0;
        idle();
        bus.raA = '0;
        bus.raB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_vl", bus.vl, 0);
        check("rst_vtype", bus.vtype, 0);
        check("rst_avl", bus.AVL_reg, 0);
        for (int r = 0; r < NREG; r += 5) begin
            bus.raA = 5'(r);
            #1;
            check($sformatf("rst_rd%0d", r), bus.rdA, 0);
            check($sformatf("rst_busy%0d", r), bus.busyA, 0);
        end

        // Table-driven vectors through the scoreboard queue
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            drive(v.cfg, v.vt, v.avl, v.wen, v.wa, v.wd, v.vm, v.sb, v.sba);
            sbq.push_back(v.e);
            step();
            bus.raA = v.ra;
            bus.raB = v.ra;
            #1;
            e = sbq.pop_front();
            check($sformatf("v%0d_vl", i), bus.vl, e.vl);
            check($sformatf("v%0d_vtype", i), bus.vtype, e.vtype);
            check($sformatf("v%0d_avl", i), bus.AVL_reg, e.avl);
            check($sformatf("v%0d_rdA", i), bus.rdA, e.rd);
            check($sformatf("v%0d_rdB", i), bus.rdB, e.rd);
            check($sformatf("v%0d_busyA", i), bus.busyA, e.busy);
            check($sformatf("v%0d_busyB", i), bus.busyB, e.busy);
        end

        // Mask-accurate bypass: v0 = 0x05, SEW=8, vl=8
        @(negedge clk);
        drive(1'b0, 7'h00, 8'd0, 1'b1, 5'd0, 64'h5, 1'b1, 1'b0, 5'd0);
        step();
        bus.raA = 5'd0;
        #1;
        check("v0_load", bus.rdA, 64'h5);
        @(negedge clk);
        drive(1'b0, 7'h00, 8'd0, 1'b1, 5'd12, 64'h1122334455667788, 1'b0, 1'b0, 5'd0);
        bus.raA = 5'd12;
        bus.raB = 5'd0;
        #1;
        check("bypass_rdA", bus.rdA, 64'h0000_0000_0066_0088);
        check("bypass_rdB_v0", bus.rdB, 64'h5);
        step();
        bus.raA = 5'd12;
        #1;
        check("masked_commit", bus.rdA, 64'h0000_0000_0066_0088);

        // Scoreboard set / set-wins / clear
        @(negedge clk);
        drive(1'b0, 7'h00, 8'd0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1, 5'd7);
        bus.raA = 5'd7;
        bus.raB = 5'd3;
        #1;
        check("sb_no_fwd", bus.busyA, 0);
        check("sb_busyB_r3", bus.busyB, 1);
        step();
        bus.raA = 5'd7;
        #1;
        check("sb_set", bus.busyA, 1);
        @(negedge clk);
        drive(1'b0, 7'h00, 8'd0, 1'b1, 5'd7, 64'h0, 1'b1, 1'b1, 5'd7);
        step();
        bus.raA = 5'd7;
        #1;
        check("sb_set_wins", bus.busyA, 1);
        @(negedge clk);
        drive(1'b0, 7'h00, 8'd0, 1'b1, 5'd7, 64'h0, 1'b1, 1'b0, 5'd0);
        step();
        bus.raA = 5'd7;
        #1;
        check("sb_clear", bus.busyA, 0);

        // Reset mid-stream overrides cfg, write and scoreboard set
        @(negedge clk);
        drive(1'b1, 7'h00, 8'd3, 1'b1, 5'd1, ONES, 1'b1, 1'b1, 5'd21);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_vl", bus.vl, 0);
        check("mid_rst_vtype", bus.vtype, 0);
        check("mid_rst_avl", bus.AVL_reg, 0);
        for (int r = 0; r < NREG; r++) begin
            bus.raA = 5'(r);
            #1;
            check($sformatf("mid_rst_rd%0d", r), bus.rdA, 0);
            check($sformatf("mid_rst_busy%0d", r), bus.busyA, 0);
        end

`ifdef VRF_VSTART_EN
        // vstart: SEW=16, vl=4, vstart=2 -> only elements 2..3 written
        @(negedge clk);
        drive(1'b1, 7'h08, 8'd4, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 5'd0);
        bus.vstart = 4'd2;
        step();
        #1;
        check("vs_vl", bus.vl, 4);
        check("vs_vstart_q", bus.vstart_q, 2);
        @(negedge clk);
        drive(1'b0, 7'h00, 8'd0, 1'b1, 5'd2, ONES, 1'b1, 1'b0, 5'd0);
        bus.raA = 5'd2;
        #1;
        check("vs_bypass", bus.rdA, 64'hFFFF_FFFF_0000_0000);
        step();
        bus.raA = 5'd2;
        #1;
        check("vs_commit", bus.rdA, 64'hFFFF_FFFF_0000_0000);
        check("vs_cleared", bus.vstart_q, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
